tag_fifo: RTL
=============

TAG_FIFO -- requirements
Module: tag_fifo

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Tag_pop  input  1  dispatch consumes Tag_out this cycle.
REQ-004 SHALL have port: Tag_out  output  5  tag currently at FIFO head (first-word fall-through).
REQ-005 SHALL have port: Tag_empty  output  1  no free tags; Tag_out is not valid.
REQ-006 SHALL have port: Tag_full  output  1  all 32 tags free.
REQ-007 SHALL have port: Tag_count  output  6  number of free tags, 0..32.
REQ-008 SHALL have port: Retire_rd_tag  input  5  tag released by the retiring instruction.
REQ-009 SHALL have port: Retire_valid  input  1  Retire_rd_tag is valid and is returned this cycle.
REQ-010 SHALL have port: Flush  input  1  mispredict recovery; every tag becomes free.
REQ-011 SHALL have port: Overflow_err  output  1  sticky; push attempted while full.
REQ-012 SHALL have port: Underflow_err  output  1  sticky; pop attempted while empty.

Function
REQ-013 SHALL hold 32 entries of 5 bits, a 5-bit read pointer, a 5-bit write pointer and a 6-bit count.
REQ-014 SHALL drive Tag_out combinationally from entry[rd_ptr]; value is don't-care when Tag_empty=1.
REQ-015 SHALL derive Tag_empty = (count==0) and Tag_full = (count==32) from registered count only, with no same-cycle bypass.
REQ-016 Pop SHALL occur when Tag_pop=1 and Tag_empty=0: rd_ptr+1 mod 32, count-1, visible next cycle.
REQ-017 Push SHALL occur when Retire_valid=1 and Tag_full=0: entry[wr_ptr]<=Retire_rd_tag, wr_ptr+1 mod 32, count+1.
REQ-018 Simultaneous valid pop and push SHALL both occur, with count unchanged.
REQ-019 Pop while empty SHALL be ignored even if a push occurs the same cycle; pointers and count unchanged except for the push; Underflow_err<=1.
REQ-020 Push while full SHALL be ignored (tag discarded, state unchanged); Overflow_err<=1.
REQ-021 Pointers SHALL wrap 31->0 with no gap or skipped entry.
REQ-022 Flush=1 SHALL, on the next edge, reinitialise entry[i]<=i for i=0..31, rd_ptr<=0, wr_ptr<=0, count<=32.
REQ-023 Flush SHALL take priority over any same-cycle pop or push, and that pop or push SHALL NOT set either error flag.
REQ-024 Flush SHALL NOT clear Overflow_err or Underflow_err.
REQ-025 Tag issue order SHALL be strict FIFO: tags are returned to dispatch in the order pushed, after the initial 0..31 sequence.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set entry[i]<=i, rd_ptr<=0, wr_ptr<=0, count<=32, Overflow_err<=0, Underflow_err<=0.
REQ-027 After reset the outputs SHALL be Tag_out=0, Tag_empty=0, Tag_full=1, Tag_count=32.
REQ-028 Reset SHALL take priority over Flush, Tag_pop and Retire_valid; reset asserted mid-operation discards all in-flight state.
REQ-029 Only reset SHALL clear the error flags.

Verification
REQ-030 Bench SHALL cover: reset, then Tag_pop=1 for 3 cycles -> Tag_out 0,1,2 on successive cycles; Tag_count 32->29; Tag_full=0 after the first pop.
REQ-031 Bench SHALL cover: 32 pops -> Tag_empty=1 and Tag_count=0; a 33rd pop -> ignored, Underflow_err=1.
REQ-032 Bench SHALL cover: when empty, push tag 7 with Tag_pop=1 in the same cycle -> pop ignored, Underflow_err=1; next cycle Tag_out=7, Tag_count=1.
REQ-033 Bench SHALL cover: count=10 with simultaneous pop and push of tag 5 -> Tag_count stays 10; tag 5 is issued after the 9 older entries; pointer wrap exercised by running >64 push/pop pairs.
REQ-034 Bench SHALL cover: count=4 with Flush=1 plus Tag_pop=1 and Retire_valid=1 -> next cycle Tag_count=32, Tag_out=0, no error flag set; when full, push tag 3 -> Overflow_err=1 and count stays 32.

Source files
------------

// File: rtl/tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
//
// Free-list of physical destination tags for the rename/dispatch stage.
// The FIFO holds the 32 tags that are currently unallocated. Dispatch takes
// the head tag (first-word fall-through), and retirement returns a tag to the
// tail. A flush (mispredict recovery) returns every tag at once by
// reinitialising the list to 0..31.
//
// Ports
//   clk            sole clock, all state changes on its rising edge
//   reset          synchronous, active-high; restores the 0..31 list and
//                  clears the sticky error flags
//   Tag_pop        dispatch consumes Tag_out this cycle
//   Tag_out        tag at the head of the free list (valid when !Tag_empty)
//   Tag_empty      no free tags remain
//   Tag_full       all 32 tags are free
//   Tag_count      number of free tags, 0..32
//   Retire_rd_tag  tag being returned by the retiring instruction
//   Retire_valid   Retire_rd_tag is returned this cycle
//   Flush          every tag becomes free on the next edge
//   Overflow_err   sticky: a return was attempted while the list was full
//   Underflow_err  sticky: a dispatch pop was attempted while empty
// ----------------------------------------------------------------------------
module tag_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tag_pop,
    output logic [4:0] Tag_out,
    output logic       Tag_empty,
    output logic       Tag_full,
    output logic [5:0] Tag_count,
    input  logic [4:0] Retire_rd_tag,
    input  logic       Retire_valid,
    input  logic       Flush,
    output logic       Overflow_err,
    output logic       Underflow_err
);

    localparam int DEPTH = 32;

    logic [4:0] entry [DEPTH];
    logic [4:0] rd_ptr;
    logic [4:0] wr_ptr;
    logic [5:0] count;
    logic       overflow_q;
    logic       underflow_q;

    logic       list_empty;
    logic       list_full;
    logic       do_pop;
    logic       do_push;
    logic       bad_pop;
    logic       bad_push;
    logic [5:0] count_next;

    // Status is taken from the registered count only, so a push in the same
    // cycle cannot rescue a pop from an empty list (and vice versa).
    always_comb begin
        list_empty = (count == 6'd0);
        list_full  = (count == 6'd32);
    end

    // Qualify the requests. Flush wins over both, and a request that loses
    // to a flush is simply dropped rather than being reported as an error.
    always_comb begin
        do_pop   = Tag_pop      && !list_empty && !Flush;
        do_push  = Retire_valid && !list_full  && !Flush;
        bad_pop  = Tag_pop      &&  list_empty && !Flush;
        bad_push = Retire_valid &&  list_full  && !Flush;
    end

    // A simultaneous pop and push leaves the occupancy unchanged.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 6'd1;
            2'b01:   count_next = count - 6'd1;
            default: count_next = count;
        endcase
    end

    // Pointer, count and storage update. Reset and flush both rebuild the
    // identity list 0..31; only reset touches the error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= 5'(i);
            end
            rd_ptr      <= 5'd0;
            wr_ptr      <= 5'd0;
            count       <= 6'd32;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= 5'(i);
            end
            rd_ptr <= 5'd0;
            wr_ptr <= 5'd0;
            count  <= 6'd32;
        end else begin
            if (do_push) begin
                entry[wr_ptr] <= Retire_rd_tag;
                wr_ptr        <= wr_ptr + 5'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 5'd1;
            end
            count <= count_next;
            if (bad_push) begin
                overflow_q <= 1'b1;
            end
            if (bad_pop) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Output mapping; the head tag falls through with no register stage.
    always_comb begin
        Tag_out       = entry[rd_ptr];
        Tag_empty     = list_empty;
        Tag_full      = list_full;
        Tag_count     = count;
        Overflow_err  = overflow_q;
        Underflow_err = underflow_q;
    end

endmodule
